// File: rtl/w_sched_if.sv
// Purpose: start/ready block intake plus valid/ready schedule-word stream of w_sched_ctrl.
// Signals:
//   start, message_block, start_ready  - block intake handshake (message_block word 0 = [511:480])
//   w_valid, w_ready, w_word, w_index  - schedule word stream toward the round engine
//   busy, done                         - status (done is a one-cycle pulse)
// Modports: slave = scheduler side, master = padder/round-engine side.
interface w_sched_if #(
  parameter int unsigned W_LENGTH = 64
);
  localparam int unsigned IDX_W = $clog2(W_LENGTH) + 1;

  logic             start;
  logic             start_ready;
  logic [511:0]     message_block;
  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w_word;
  logic [IDX_W-1:0] w_index;
  logic             busy;
  logic             done;

  modport slave (
    input  start, message_block, w_ready,
    output start_ready, w_valid, w_word, w_index, busy, done
  );

  modport master (
    output start, message_block, w_ready,
    input  start_ready, w_valid, w_word, w_index, busy, done
  );
endinterface

// File: rtl/w_sched_ctrl.sv
// Purpose: streams the SHA-256 message schedule W[0..W_LENGTH-1] for one 512-bit block.
//   W[0..15] come straight from the block, later words are expanded in a 16-word
//   sliding window, one word per accepted beat with no bubbles.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high reset
//   abort  - (only with W_SCHED_ABORT_EN) drop the current block and return to IDLE
//   bus    - w_sched_if.slave: start/start_ready/message_block intake,
//            w_valid/w_ready/w_word/w_index stream, busy, done
// Parameter: W_LENGTH = number of schedule words per block (16..64).
// Optional feature macro: W_SCHED_ABORT_EN.
module w_sched_ctrl #(
  parameter int unsigned W_LENGTH = 64
) (
  input  logic       clock,
  input  logic       reset,
`ifdef W_SCHED_ABORT_EN
  input  logic       abort,
`endif
  w_sched_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(W_LENGTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W_LENGTH - 1);
  localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(15);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      win_q [16];
  logic [31:0]      win_d [16];
  logic [31:0]      w_word_q, w_word_d;
  logic [IDX_W-1:0] w_index_q, w_index_d;
  logic             w_valid_q, w_valid_d;
  logic             start_ready_q, start_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             abort_req;
  logic [31:0]      w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef W_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Window holds W[t..t+15]; the word entering at the top is W[t+16].
  assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  assign accept = w_valid_q && bus.w_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    w_word_d  = w_word_q;
    w_index_d = w_index_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int k = 0; k < 16; k++) begin
            win_d[k] = bus.message_block[511 - 32*k -: 32];
          end
          w_word_d  = bus.message_block[511 -: 32];
          w_index_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD, EXPAND: begin
        if (abort_req) begin
          w_index_d = '0;
          state_d   = IDLE;
        end else if (accept) begin
          // Shift on every accepted beat so the next word is already registered.
          for (int k = 0; k < 15; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[15] = w_next;
          w_word_d  = win_q[1];
          if (w_index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            w_index_d = w_index_q + IDX_W'(1);
            if (w_index_q == LOAD_END) begin
              state_d = EXPAND;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    w_valid_d     = (state_d == LOAD) || (state_d == EXPAND);
    busy_d        = (state_d == LOAD) || (state_d == EXPAND);
    start_ready_d = (state_d == IDLE);
    done_d        = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= '{default: '0};
      w_word_q      <= '0;
      w_index_q     <= '0;
      w_valid_q     <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      w_word_q      <= w_word_d;
      w_index_q     <= w_index_d;
      w_valid_q     <= w_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.w_valid     = w_valid_q;
  assign bus.w_word      = w_word_q;
  assign bus.w_index     = w_index_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Purpose: directed self-checking bench for w_sched_ctrl ("abc" block, stalls,
//   mid-run reset, held start with block change, optional abort).
module tb_w_sched_ctrl #(
  parameter int unsigned WL = 64
);
  localparam int unsigned IDX_W = $clog2(WL) + 1;

  logic clock = 1'b0;
  logic reset;
`ifdef W_SCHED_ABORT_EN
  logic abort;
`endif

  w_sched_if #(.W_LENGTH(WL)) bus ();

  w_sched_ctrl #(.W_LENGTH(WL)) dut (
    .clock (clock),
    .reset (reset),
`ifdef W_SCHED_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks;
  int n_errors;
  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];
  logic [511:0] blk_abc;
  logic [511:0] blk_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule, computed index-wise over the whole array.
  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ms1(exp_w[t-2]) + exp_w[t-7] + ms0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Consume the stream from the current cycle (c=1 is the first W0 cycle) until done.
  task automatic run_stream(input int mode, input int change_at, input logic [511:0] new_blk,
                            output int done_cyc, output int beats);
    int c;
    logic stalled;
    logic [31:0] pw;
    logic [IDX_W-1:0] pi;
    done_cyc = -1;
    beats    = 0;
    stalled  = 1'b0;
    pw       = '0;
    pi       = '0;
    c        = 1;
    while (c < 400 && done_cyc < 0) begin
      bus.w_ready = (mode == 0) ? 1'b1 : c[0];
      if (c == change_at) bus.message_block = new_blk;
      if (stalled) begin
        check("hold_valid", 64'(bus.w_valid), 64'd1);
        check("hold_word", 64'(bus.w_word), 64'(pw));
        check("hold_idx", 64'(bus.w_index), 64'(pi));
      end
      if (bus.done) begin
        done_cyc = c;
        check("done_valid_low", 64'(bus.w_valid), 64'd0);
      end else if (bus.w_valid) begin
        if (bus.w_ready && beats < 64) begin
          check("w_idx", 64'(bus.w_index), 64'(beats));
          check("w_word", 64'(bus.w_word), 64'(exp_w[beats]));
          got_w[beats] = bus.w_word;
          beats++;
        end
        stalled = !bus.w_ready;
        pw = bus.w_word;
        pi = bus.w_index;
      end else begin
        stalled = 1'b0;
      end
      if (done_cyc < 0) begin
        tick();
        c++;
      end
    end
    if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic start_block(input logic [511:0] blk);
    bus.message_block = blk;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int dc, beats, k;
    logic seen_done;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.message_block = '0;
    bus.w_ready = 1'b0;
`ifdef W_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    blk_abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) blk_b[511 - 32*i -: 32] = 32'h11111111 * (i + 1) ^ 32'h80000001;

    tick();
    tick();
    check("rst_start_ready", 64'(bus.start_ready), 64'd1);
    check("rst_w_valid", 64'(bus.w_valid), 64'd0);
    check("rst_w_word", 64'(bus.w_word), 64'd0);
    check("rst_w_index", 64'(bus.w_index), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    tick();

    // Full-rate "abc" run.
    build_model(blk_abc);
    start_block(blk_abc);
    check("t1_lat_valid", 64'(bus.w_valid), 64'd1);
    check("t1_w0", 64'(bus.w_word), 64'h61626380);
    check("t1_busy", 64'(bus.busy), 64'd1);
    check("t1_start_ready", 64'(bus.start_ready), 64'd0);
    run_stream(0, 0, '0, dc, beats);
    check("t1_done_cyc", 64'(dc), 64'(WL + 1));
    check("t1_beats", 64'(beats), 64'(WL));
    check("t1_W15", 64'(got_w[15]), 64'h00000018);
    if (beats > 17) begin
      check("t1_W16", 64'(got_w[16]), 64'h61626380);
      check("t1_W17", 64'(got_w[17]), 64'h000F0000);
    end
    tick();
    check("t1_done_pulse", 64'(bus.done), 64'd0);
    check("t1_idle_ready", 64'(bus.start_ready), 64'd1);

    // Same block with w_ready toggling.
    start_block(blk_abc);
    run_stream(1, 0, '0, dc, beats);
    check("t2_done_cyc", 64'(dc), 64'(2 * WL));
    check("t2_beats", 64'(beats), 64'(WL));
    tick();

    // Reset in the middle of the expansion.
    start_block(blk_abc);
    bus.w_ready = 1'b1;
    k = 0;
    while (bus.w_index != IDX_W'(20) && k < 100) begin
      tick();
      k++;
    end
    check("t3_reach20", 64'(bus.w_index), 64'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t3_w_valid", 64'(bus.w_valid), 64'd0);
    check("t3_busy", 64'(bus.busy), 64'd0);
    check("t3_start_ready", 64'(bus.start_ready), 64'd1);
    check("t3_w_index", 64'(bus.w_index), 64'd0);
    seen_done = bus.done;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_done = seen_done | bus.done;
    end
    check("t3_no_done", 64'(seen_done), 64'd0);
    start_block(blk_abc);
    check("t3_restart_w0", 64'(bus.w_word), 64'h61626380);
    run_stream(0, 0, '0, dc, beats);
    check("t3_done_cyc", 64'(dc), 64'(WL + 1));
    tick();

    // start held high, block changed mid-run; new block taken one idle cycle after done.
    bus.message_block = blk_abc;
    bus.start = 1'b1;
    tick();
    run_stream(0, 5, blk_b, dc, beats);
    check("t4_done_cyc", 64'(dc), 64'(WL + 1));
    check("t4_beats", 64'(beats), 64'(WL));
    tick();
    check("t4_idle_ready", 64'(bus.start_ready), 64'd1);
    check("t4_idle_valid", 64'(bus.w_valid), 64'd0);
    tick();
    bus.start = 1'b0;
    check("t4_new_valid", 64'(bus.w_valid), 64'd1);
    check("t4_new_w0", 64'(bus.w_word), 64'(blk_b[511 -: 32]));
    build_model(blk_b);
    run_stream(0, 0, '0, dc, beats);
    check("t4b_done_cyc", 64'(dc), 64'(WL + 1));
    tick();

`ifdef W_SCHED_ABORT_EN
    // Abort mid-run, then abort while idle.
    build_model(blk_abc);
    start_block(blk_abc);
    bus.w_ready = 1'b1;
    k = 0;
    while (bus.w_index != IDX_W'(40) && k < 100) begin
      tick();
      k++;
    end
    check("t5_reach40", 64'(bus.w_index), 64'd40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_w_valid", 64'(bus.w_valid), 64'd0);
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_start_ready", 64'(bus.start_ready), 64'd1);
    seen_done = bus.done;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_done = seen_done | bus.done;
    end
    check("t5_no_done", 64'(seen_done), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle_abort_ready", 64'(bus.start_ready), 64'd1);
    check("t5_idle_abort_busy", 64'(bus.busy), 64'd0);
    start_block(blk_abc);
    check("t5_restart_w0", 64'(bus.w_word), 64'h61626380);
    run_stream(0, 0, '0, dc, beats);
    check("t5_done_cyc", 64'(dc), 64'(WL + 1));
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
